// File: rtl/tsn_switch_pkg.sv
// Shared definitions for the switch lookup path.
// Contents:
//   MAC_W        - MAC address width
//   PORT_FIELD_W - width of the stored port bitmap (covers the widest src_port)
//   AGE_FIELD_W  - width of the stored age counter (covers AGE_BITS up to 8)
//   GROUP_BIT    - index of the group/multicast bit inside a MAC
//   lut_entry_t  - one table entry {valid, mac, port, age}
//   flood_mask() - every port except the one the frame came in on
package tsn_switch_pkg;

  localparam int MAC_W        = 48;
  localparam int PORT_FIELD_W = 16;
  localparam int AGE_FIELD_W  = 8;
  localparam int GROUP_BIT    = 0;

  // Port and age fields are stored at their widest size so one entry type
  // fits every parameterisation; unused upper bits are always zero.
  typedef struct packed {
    logic                    valid;
    logic [MAC_W-1:0]        mac;
    logic [PORT_FIELD_W-1:0] port;
    logic [AGE_FIELD_W-1:0]  age;
  } lut_entry_t;

  // Caller truncates the result to its own port count.
  function automatic logic [PORT_FIELD_W-1:0] flood_mask(input logic [PORT_FIELD_W-1:0] src_port);
    return ~src_port;
  endfunction

endpackage

// File: rtl/mac_port_lut_if.sv
// Bus between the header parser (master) and the output-port lookup (slave).
// Signals:
//   dst_mac/dst_lut_flag  - lookup request (flag is a one-cycle pulse)
//   src_mac/src_lut_flag  - learn request (flag is a one-cycle pulse)
//   src_port              - one-hot ingress port, low NUM_QUEUES bits meaningful
//   dst_ports             - resolved output-port bitmap, valid with lookup_valid
//   lookup_valid          - one-cycle result pulse
//   lookup_hit            - destination was found in the table
//   lut_full              - every table entry is in use
interface mac_port_lut_if #(
  parameter int NUM_QUEUES = 4
);
  import tsn_switch_pkg::*;

  logic [MAC_W-1:0]      dst_mac;
  logic                  dst_lut_flag;
  logic [MAC_W-1:0]      src_mac;
  logic                  src_lut_flag;
  logic [15:0]           src_port;
  logic [NUM_QUEUES-1:0] dst_ports;
  logic                  lookup_valid;
  logic                  lookup_hit;
  logic                  lut_full;

  modport master (
    output dst_mac, dst_lut_flag, src_mac, src_lut_flag, src_port,
    input  dst_ports, lookup_valid, lookup_hit, lut_full
  );

  modport slave (
    input  dst_mac, dst_lut_flag, src_mac, src_lut_flag, src_port,
    output dst_ports, lookup_valid, lookup_hit, lut_full
  );

endinterface

// File: rtl/mac_lut_age_timer.sv
// Aging prescaler for the MAC table.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high reset
//   tick  - high for one cycle every AGE_TICK_CYCLES cycles (the wrap cycle)
module mac_lut_age_timer #(
  parameter int AGE_TICK_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int               CNT_W = $clog2(AGE_TICK_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(AGE_TICK_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mac_port_lut.sv
// Output-port lookup stage: fully associative MAC table that learns
// {source MAC -> ingress port}, resolves destination MACs to a port bitmap,
// ages out idle entries and replaces round-robin when full.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high reset
//   bus   - mac_port_lut_if slave: learn/lookup requests in, result and
//           lut_full out (all outputs registered)
module mac_port_lut
  import tsn_switch_pkg::*;
#(
  parameter int NUM_QUEUES      = 4,
  parameter int LUT_DEPTH       = 8,
  parameter int AGE_BITS        = 3,
  parameter int AGE_TICK_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           reset,
  mac_port_lut_if.slave  bus
);

  localparam int                     IDX_W    = $clog2(LUT_DEPTH);
  localparam logic [AGE_FIELD_W-1:0] AGE_FULL = AGE_FIELD_W'((1 << AGE_BITS) - 1);

  lut_entry_t lut [LUT_DEPTH];
  logic [IDX_W-1:0] rr_ptr;
  logic             tick;

  logic [NUM_QUEUES-1:0]   in_port;
  logic [PORT_FIELD_W-1:0] in_port_field;

  logic             dst_hit;
  logic [IDX_W-1:0] dst_idx;
  logic             src_hit;
  logic [IDX_W-1:0] src_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             all_valid;
  logic             learn_en;
  logic             learn_replace;
  logic [IDX_W-1:0] learn_idx;

  logic [NUM_QUEUES-1:0] ports_q;
  logic                  valid_q;
  logic                  hit_q;
  logic                  full_q;

  mac_lut_age_timer #(
    .AGE_TICK_CYCLES (AGE_TICK_CYCLES)
  ) u_age_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign in_port       = bus.src_port[NUM_QUEUES-1:0];
  assign in_port_field = PORT_FIELD_W'(in_port);

  // Match search for both requests against the current (pre-write) table,
  // so a lookup in the same cycle as a learn never sees the new entry.
  always_comb begin
    dst_hit    = 1'b0;
    dst_idx    = '0;
    src_hit    = 1'b0;
    src_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    all_valid  = 1'b1;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      if (lut[i].valid && lut[i].mac == bus.dst_mac) begin
        dst_hit = 1'b1;
        dst_idx = IDX_W'(i);
      end
      if (lut[i].valid && lut[i].mac == bus.src_mac) begin
        src_hit = 1'b1;
        src_idx = IDX_W'(i);
      end
      if (!lut[i].valid) begin
        all_valid = 1'b0;
      end
    end
    // Walk downward so the lowest-index free slot is the one that sticks.
    for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
      if (!lut[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Group sources and port-less requests are never learned.
  assign learn_en      = bus.src_lut_flag && !bus.src_mac[GROUP_BIT] && (in_port != '0);
  assign learn_replace = learn_en && !src_hit && !free_found;
  assign learn_idx     = src_hit ? src_idx : (free_found ? free_idx : rr_ptr);

  // Table state: aging first, then the learn write so a refresh on a tick
  // cycle leaves the entry valid with full age.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut[i] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        if (tick && lut[i].valid && lut[i].age != '0) begin
          lut[i].age <= lut[i].age - 1'b1;
          if (lut[i].age == AGE_FIELD_W'(1)) begin
            lut[i].valid <= 1'b0;
          end
        end
      end
      if (learn_en) begin
        lut[learn_idx].valid <= 1'b1;
        lut[learn_idx].mac   <= bus.src_mac;
        lut[learn_idx].port  <= in_port_field;
        lut[learn_idx].age   <= AGE_FULL;
      end
      // Depth is a power of two, so the pointer wraps naturally.
      if (learn_replace) begin
        rr_ptr <= rr_ptr + 1'b1;
      end
    end
  end

  // Registered lookup result; lut_full trails the table by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      ports_q <= '0;
      full_q  <= 1'b0;
    end else begin
      valid_q <= bus.dst_lut_flag;
      full_q  <= all_valid;
      if (bus.dst_lut_flag) begin
        if (!bus.dst_mac[GROUP_BIT] && dst_hit) begin
          hit_q <= 1'b1;
          // Never send a frame back out of the port it arrived on.
          if (lut[dst_idx].port == in_port_field) begin
            ports_q <= '0;
          end else begin
            ports_q <= lut[dst_idx].port[NUM_QUEUES-1:0];
          end
        end else begin
          hit_q   <= 1'b0;
          ports_q <= NUM_QUEUES'(flood_mask(bus.src_port));
        end
      end
    end
  end

  assign bus.dst_ports    = ports_q;
  assign bus.lookup_valid = valid_q;
  assign bus.lookup_hit   = hit_q;
  assign bus.lut_full     = full_q;

endmodule
